// File: rtl/sram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : sram_stream_reader
// Description : Burst read streamer for a single-port SRAM with a one-cycle
//               registered read, delivering words on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================

module sram_stream_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_ceb_o,
  output logic              mem_web_o,
  output logic [ADDR_W-1:0] mem_a_o,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(2 ** ADDR_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_base;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_issued;
  logic [LEN_W-1:0]    r_popped;
  logic                r_pending;
  logic [ADDR_W-1:0]   r_last_addr;

  logic [DATA_W-1:0]   r_buf [0:1];
  logic                r_wptr;
  logic                r_rptr;
  logic [1:0]          r_count;

  logic                w_pop;
  logic [1:0]          w_fill;
  logic                w_room;
  logic                w_issue;
  logic [ADDR_W-1:0]   w_issue_addr;
  logic [LEN_W-1:0]    w_len_clamped;
  logic                w_latch;
  logic                w_done;

  assign w_pop         = valid_o & ready_i;
  assign w_fill        = r_count + {1'b0, r_pending};
  // A full pipeline may still issue when a pop frees a slot in the same cycle.
  assign w_room        = (w_fill < 2'd2) | ((w_fill == 2'd2) & w_pop);
  assign w_issue       = (r_state == S_RUN) & (r_issued != r_len) & w_room;
  assign w_issue_addr  = r_base + r_issued[ADDR_W-1:0];
  assign w_len_clamped = (len_i > C_MAX_LEN) ? C_MAX_LEN : len_i;

  assign mem_ceb_o = ~w_issue;
  assign mem_web_o = 1'b1;
  assign mem_a_o   = w_issue ? w_issue_addr : r_last_addr;

  assign valid_o = (r_count != 2'd0);
  assign data_o  = r_buf[r_rptr];
  assign busy_o  = (r_state != S_IDLE);
  assign done_o  = w_done;

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_latch     = 1'b1;
          w_state_nxt = (w_len_clamped == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (w_issue && ((r_issued + LEN_W'(1)) == r_len)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_popped == r_len) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_base      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_pending   <= 1'b0;
      r_last_addr <= '0;
    end else begin
      if (w_latch) begin
        r_base   <= base_addr_i;
        r_len    <= w_len_clamped;
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if (w_issue) r_issued <= r_issued + LEN_W'(1);
        if (w_pop)   r_popped <= r_popped + LEN_W'(1);
      end
      r_pending <= w_issue;
      if (w_issue) r_last_addr <= w_issue_addr;
    end
  end

  // Read data lands in the buffer the edge after the SRAM executes the read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_pending) begin
        r_buf[r_wptr] <= mem_q_i;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, r_pending} - {1'b0, w_pop};
    end
  end

endmodule

`default_nettype wire
